// File: rtl/t03_wb_scheduler.sv
// t03_wb_scheduler
// Write-back scheduler for the 32x32 register file. Two requesters share the
// single write port: the execute path (ALU result / JAL link) and the
// load-return path. Execute writes are buffered in a small FIFO while a load
// return owns the port. One load may be outstanding at a time. Decode receives
// a hazard flag for any source register whose write has not landed yet.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   ex_valid/ex_ready/ex_rd/ex_data
//                                execute write request; ready = FIFO not full
//   ld_issue/ld_issue_ready/ld_rd
//                                load issue; ready = no load outstanding
//   mem_valid/mem_data           load data return
//   rs1_idx/rs2_idx/hazard       decode source indices and stall flag
//   rf_we/rf_waddr/rf_wdata      registered register-file write port
//   stall_cnt                    (T03_WB_STATS_EN only) saturating count of
//                                cycles with ex_valid=1 and ex_ready=0
//
// Optional feature macro: T03_WB_STATS_EN
//
// Load FSM states:
//   state | meaning
//   IDLE  | no load outstanding; ld_issue accepted
//   WAIT  | load outstanding; waiting for mem_valid

module t03_wb_scheduler #(
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_data,
  input  logic          ld_issue,
  output logic          ld_issue_ready,
  input  logic [AW-1:0] ld_rd,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_data,
  input  logic [AW-1:0] rs1_idx,
  input  logic [AW-1:0] rs2_idx,
  output logic          hazard,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
`ifdef T03_WB_STATS_EN
  output logic [DW-1:0] rf_wdata,
  output logic [15:0]   stall_cnt
`else
  output logic [DW-1:0] rf_wdata
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ld_state_t;

  ld_state_t     state;
  logic [AW-1:0] pend_rd;
  logic          squash;

  // FIFO kept as packed shift registers: entry 0 is the head, a pop shifts
  // everything down by one slot, so no pointers are needed for any depth.
  logic [BUF_DEPTH-1:0]    vld_q, vld_n;
  logic [BUF_DEPTH*AW-1:0] rd_q, rd_n;
  logic [BUF_DEPTH*DW-1:0] dat_q, dat_n;

  logic ex_acc, ex_wr, ld_ret, ld_wr;
  logic fifo_pop, fifo_push, ex_bypass;
  logic fifo_hit1, fifo_hit2, hit1, hit2;

  // Readiness ignores a same-cycle pop so it never depends on the load path.
  assign ex_ready  = ~vld_q[BUF_DEPTH-1];
  assign ex_acc    = ex_valid & ex_ready;
  // Writes to x0 are accepted but never enter the FIFO or the write port.
  assign ex_wr     = ex_acc & (ex_rd != '0);
  assign ld_ret    = (state == WAIT) & mem_valid;
  assign ld_wr     = ld_ret & ~squash & (pend_rd != '0);
  assign fifo_pop  = ~ld_ret & vld_q[0];
  assign ex_bypass = ~ld_ret & ~vld_q[0] & ex_wr;
  assign fifo_push = ex_wr & ~ex_bypass;

  always_comb begin
    vld_n = vld_q;
    rd_n  = rd_q;
    dat_n = dat_q;
    if (fifo_pop) begin
      vld_n = vld_q >> 1;
      rd_n  = rd_q >> AW;
      dat_n = dat_q >> DW;
    end
    if (fifo_push) begin
      // Entries stay contiguous from slot 0, so the first free slot after
      // the optional shift is the tail.
      for (int i = BUF_DEPTH - 1; i >= 0; i--) begin
        if (!vld_n[i] && (i == 0 || vld_n[(i > 0) ? i - 1 : 0])) begin
          vld_n[i]            = 1'b1;
          rd_n[i*AW +: AW]    = ex_rd;
          dat_n[i*DW +: DW]   = ex_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      rd_q  <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_n;
      rd_q  <= rd_n;
      dat_q <= dat_n;
    end
  end

  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (vld_q[i] && rd_q[i*AW +: AW] == rs1_idx) fifo_hit1 = 1'b1;
      if (vld_q[i] && rd_q[i*AW +: AW] == rs2_idx) fifo_hit2 = 1'b1;
    end
  end

  // A squashed load never writes, so it is not a hazard source.
  assign hit1 = (rs1_idx != '0) &
                (((state == WAIT) & ~squash & (pend_rd == rs1_idx)) |
                 fifo_hit1 |
                 (rf_we & (rf_waddr == rs1_idx)) |
                 (ex_acc & (ex_rd == rs1_idx)));
  assign hit2 = (rs2_idx != '0) &
                (((state == WAIT) & ~squash & (pend_rd == rs2_idx)) |
                 fifo_hit2 |
                 (rf_we & (rf_waddr == rs2_idx)) |
                 (ex_acc & (ex_rd == rs2_idx)));
  assign hazard = hit1 | hit2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= ld_wr | fifo_pop | ex_bypass;
      if (ld_wr) begin
        rf_waddr <= pend_rd;
        rf_wdata <= mem_data;
      end else if (fifo_pop) begin
        rf_waddr <= rd_q[AW-1:0];
        rf_wdata <= dat_q[DW-1:0];
      end else if (ex_bypass) begin
        rf_waddr <= ex_rd;
        rf_wdata <= ex_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pend_rd        <= '0;
      squash         <= 1'b0;
      ld_issue_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (ld_issue) begin
            pend_rd        <= ld_rd;
            squash         <= 1'b0;
            state          <= WAIT;
            ld_issue_ready <= 1'b0;
          end
        end
        WAIT: begin
          // A younger execute write to the same register makes the load
          // result stale; drop it instead of overwriting newer data.
          if (ex_acc && ex_rd == pend_rd && pend_rd != '0) squash <= 1'b1;
          if (mem_valid) begin
            state          <= IDLE;
            ld_issue_ready <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          ld_issue_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef T03_WB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (ex_valid && !ex_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_t03_wb_scheduler.sv
module tb_t03_wb_scheduler;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0, ex_ready;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_data = '0;
  logic        ld_issue = 1'b0, ld_issue_ready;
  logic [4:0]  ld_rd = '0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic [4:0]  rs1_idx = '0, rs2_idx = '0;
  logic        hazard, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef T03_WB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  t03_wb_scheduler #(.AW(5), .DW(32), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk),
`ifdef T03_WB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready), .ld_rd(ld_rd),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .hazard(hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];

  // Reference model: pending execute writes in arrival order, one optional
  // outstanding load, and the last write seen on the port.
  logic [4:0]  q_rd[$];
  logic [31:0] q_d[$];
  bit          m_out, m_squash, m_lwe;
  logic [4:0]  m_rd, m_laddr;
  int          m_stall;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  function automatic bit m_hz(input logic [4:0] idx, input bit acc, input logic [4:0] erd);
    if (idx == 0) return 1'b0;
    if (m_out && !m_squash && m_rd == idx) return 1'b1;
    foreach (q_rd[i]) if (q_rd[i] == idx) return 1'b1;
    if (m_lwe && m_laddr == idx) return 1'b1;
    if (acc && erd == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    q_rd.delete();
    q_d.delete();
    m_out = 0; m_squash = 0; m_lwe = 0;
    m_rd = '0; m_laddr = '0;
    m_stall = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ex_valid = 0; ld_issue = 0; mem_valid = 0;
    ex_rd = '0; ld_rd = '0; ex_data = '0; mem_data = '0;
    rs1_idx = 5'd9; rs2_idx = 5'd3;
    model_clear();
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_ld_issue_ready", ld_issue_ready, 1);
    chk("rst_hazard", hazard, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input bit ev, input logic [4:0] erd, input logic [31:0] ed,
                      input bit li, input logic [4:0] lrd,
                      input bit mv, input logic [31:0] md,
                      input logic [4:0] r1, input logic [4:0] r2);
    wr_t w;
    bit  acc, ret, room;
    @(negedge clk);
    ex_valid = ev; ex_rd = erd; ex_data = ed;
    ld_issue = li; ld_rd = lrd;
    mem_valid = mv; mem_data = md;
    rs1_idx = r1; rs2_idx = r2;
    #1;
    room = q_rd.size() < DEPTH;
    acc  = ev && room;
    chk("ex_ready", ex_ready, room);
    chk("ld_issue_ready", ld_issue_ready, !m_out);
    chk("hazard", hazard, m_hz(r1, acc, erd) | m_hz(r2, acc, erd));
    if (ev && !room && m_stall < 16'hFFFF) m_stall++;
    ret = m_out && mv;
    w = '0;
    if (ret) begin
      w.we = (m_rd != 0) && !m_squash;
      w.a  = m_rd;
      w.d  = md;
    end
    if (acc && erd != 0) begin
      q_rd.push_back(erd);
      q_d.push_back(ed);
    end
    if (!ret && q_rd.size() > 0) begin
      w.we = 1'b1;
      w.a  = q_rd.pop_front();
      w.d  = q_d.pop_front();
    end
    exp_q.push_back(w);
    if (m_out && acc && erd == m_rd && m_rd != 0) m_squash = 1;
    if (ret) m_out = 0;
    else if (!m_out && li) begin
      m_out = 1; m_rd = lrd; m_squash = 0;
    end
    m_lwe = w.we;
    if (w.we) m_laddr = w.a;
  endtask

  task automatic idle(input logic [4:0] r1);
    step(0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  // Monitor: each cycle's registered write is compared against the oldest
  // expected write-port response.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("rf_we", rf_we, w.we);
        if (w.we) begin
          chk("rf_waddr", rf_waddr, w.a);
          chk("rf_wdata", rf_wdata, w.d);
        end
      end
    end
  end

  initial begin
    model_clear();
    do_reset();

    // execute bypass
    step(1, 5, 32'h1234, 0, 0, 0, 0, 5, 0);
    idle(5);
    idle(5);

    // load with hazard on rs1 until the write lands
    step(0, 0, 0, 1, 7, 0, 0, 7, 0);
    idle(7);
    idle(7);
    step(0, 0, 0, 0, 0, 1, 32'hDEAD, 7, 0);
    idle(7);
    idle(7);

    // load return collides with execute writes
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 3, 32'h1, 0, 0, 1, 32'h99, 3, 1);
    step(1, 4, 32'h2, 0, 0, 0, 0, 4, 3);
    idle(4);
    idle(0);

    // WAW squash
    step(0, 0, 0, 1, 9, 0, 0, 9, 0);
    step(1, 9, 32'h55, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 1, 32'h77, 9, 0);
    idle(9);
    idle(9);

    // x0 requests
    step(1, 0, 32'hAA, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hBB, 0, 0);
    idle(0);

    // reset while WAIT with a FIFO entry, then a stray mem_valid
    step(0, 0, 0, 1, 2, 0, 0, 0, 0);
    step(1, 3, 32'h33, 0, 0, 1, 32'h22, 0, 0);
    step(1, 4, 32'h44, 1, 6, 0, 0, 4, 6);
    do_reset();
    step(0, 0, 0, 0, 0, 1, 32'hCC, 6, 4);
    idle(6);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else
        step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 3, $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(0);
    idle(0);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
`ifdef T03_WB_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/t03_wb_scheduler.md
Name: t03_wb_scheduler

Overview:
- Write-back scheduler for the 32x32 register file.
- Shares the register file's single write port between two requesters: the execute path (ALU result or JAL link) and the load-return path from memory.
- Buffers execute writes while a load return owns the port, tracks one outstanding load, and raises a read-hazard flag to decode for any source register whose write has not yet landed.

Parameters:
- AW, 5: register index width.
- DW, 32: data width.
- BUF_DEPTH, 2: execute write FIFO depth (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute write request.
- ex_ready  out  1  execute request accepted this cycle (FIFO not full).
- ex_rd  in  AW  execute destination register.
- ex_data  in  DW  execute write data.
- ld_issue  in  1  load issued to memory.
- ld_issue_ready  out  1  no load outstanding.
- ld_rd  in  AW  load destination register.
- mem_valid  in  1  load data returned this cycle.
- mem_data  in  DW  returned load data.
- rs1_idx  in  AW  decode source 1 index.
- rs2_idx  in  AW  decode source 2 index.
- hazard  out  1  source register has a pending write; decode must stall.
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  AW  registered write address.
- rf_wdata  out  DW  registered write data.

Behaviour:
- Reset (async, reset_n=0):
  - load FSM in IDLE; FIFO empty; squash=0; pend_rd=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - ex_ready=1, ld_issue_ready=1, hazard=0.
  - Any in-flight load is dropped and its later mem_valid is ignored.
- Load FSM:
  - IDLE: ld_issue_ready=1. ld_issue=1 captures pend_rd=ld_rd, clears squash, and moves to WAIT.
  - WAIT: ld_issue_ready=0, so ld_issue is ignored. mem_valid=1 selects the load for the write port and returns to IDLE.
  - mem_valid in IDLE is ignored.
- Arbitration, one write selected per cycle, registered into rf_* at the next edge (rf_we high for exactly one cycle per write):
  1. Load return (WAIT and mem_valid) has highest priority.
  2. Otherwise the FIFO head is popped.
  3. Otherwise an execute request accepted this cycle bypasses the FIFO. Latency from ex accept to rf_we is 1 cycle when FIFO is empty and no load return is present.
- Execute acceptance:
  - ex_ready = FIFO not full. It is independent of ex_valid and does not count a same-cycle pop.
  - An accepted request that does not bypass is pushed.
  - If the FIFO is full and a load return occurs, no pop happens that cycle.
- Register x0:
  - An execute write with ex_rd=0 is accepted and discarded.
  - A load with ld_rd=0 still sequences IDLE->WAIT->IDLE but produces no write and no hazard.
- WAW ordering: an execute write accepted in WAIT with ex_rd==pend_rd (nonzero) sets squash. When the load returns, rf_we stays 0 and the FSM still returns to IDLE.
- hazard is combinational and asserted when rs1_idx or rs2_idx is nonzero and matches any of:
  - (a) pend_rd while in WAIT with squash=0;
  - (b) the rd of any valid FIFO entry;
  - (c) rf_waddr while rf_we=1;
  - (d) ex_rd of an accepted request this cycle.

Optional Feature:
- Macro: T03_WB_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles with ex_valid=1 and ex_ready=0.
  - Saturates at 16'hFFFF.
  - Reset to 0 by reset_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then ex_valid with ex_rd=5, ex_data=32'h1234 in cycle 0 -> rf_we=1, rf_waddr=5, rf_wdata=32'h1234 in cycle 1; ex_ready stays 1.
- ld_issue with ld_rd=7; rs1_idx=7 -> hazard=1 and ld_issue_ready=0 until the write lands. mem_valid with mem_data=32'hDEAD 3 cycles later -> next cycle rf_we=1, waddr=7, wdata=32'hDEAD; hazard=0 once rf_we drops.
- mem_valid same cycle as ex writes x3=1, x4=2 -> load write first, then x3, then x4 on consecutive cycles. ex_ready=0 only while the FIFO holds BUF_DEPTH entries.
- ld_issue with ld_rd=9, then ex write x9=32'h55 before mem_valid -> only write to x9 is 32'h55; the load return produces rf_we=0 and the FSM returns to IDLE.
- ex_rd=0 and ld_rd=0 requests -> no rf_we; hazard=0 for rs1_idx=0.
- Assert reset_n=0 while in WAIT with a FIFO entry -> outputs cleared immediately; a following mem_valid produces no write.
